// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between an instruction-fetch
// port and a data port. One access is in flight at a time. Each access runs
// IDLE -> BUSY -> RESP -> IDLE, so issues are at least 3 cycles apart.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   if_req, if_addr            fetch request (held until if_gnt) and address
//   if_gnt, if_rdata           one-cycle completion pulse and fetched word
//   dm_rd, dm_wr               data read / write request (held until dm_done)
//   dm_addr, dm_wdata          data address and store data
//   dm_done, dm_rdata          one-cycle completion pulse and load data
//   mem_en, mem_we             memory enable / write enable (registered)
//   mem_addr, mem_wdata        word-aligned address and write data (registered)
//   mem_rdata, mem_ready       memory read data and completion
//   stall                      combinational pipeline hold
//   err                        sticky error: rd+wr together, misaligned
//                              address, or memory timeout
module mem_arbiter #(
  parameter int TMO_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic [31:0] if_rdata,
  input  logic        dm_rd,
  input  logic        dm_wr,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_done,
  output logic [31:0] dm_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall,
  output logic        err
);

  localparam int            CW       = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYC - 1);

  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY, RESP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt;
  logic          last_dm;    // 1: data side was granted most recently
  logic          dm_req;
  logic          start, pick_dm, finish, tmo;
  logic [31:0]   sel_addr;
  logic [31:0]   rd_data;

  assign dm_req   = dm_rd | dm_wr;
  assign sel_addr = pick_dm ? dm_addr : if_addr;
  // A timeout completes with a zero word instead of whatever is on the bus.
  assign rd_data  = mem_ready ? mem_rdata : 32'h0;
  assign stall    = (if_req & ~if_gnt) | (dm_req & ~dm_done);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    pick_dm   = 1'b0;
    finish    = 1'b0;
    tmo       = 1'b0;
    case (state)
      IDLE: begin
        if (dm_req || if_req) begin
          start     = 1'b1;
          // On a tie the side that did not win last time goes first.
          pick_dm   = dm_req && (!if_req || !last_dm);
          state_nxt = pick_dm ? DM_BUSY : IF_BUSY;
        end
      end
      IF_BUSY, DM_BUSY: begin
        if (mem_ready) begin
          finish    = 1'b1;
          state_nxt = RESP;
        end else if (wait_cnt == TMO_LAST) begin
          finish    = 1'b1;
          tmo       = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= '0;
      last_dm   <= 1'b0;
      if_gnt    <= 1'b0;
      if_rdata  <= '0;
      dm_done   <= 1'b0;
      dm_rdata  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err       <= 1'b0;
    end else begin
      if_gnt  <= 1'b0;
      dm_done <= 1'b0;
      if (start) begin
        // The access is latched here; request changes during BUSY are ignored.
        mem_en    <= 1'b1;
        mem_we    <= pick_dm & dm_wr;   // rd+wr together executes as a write
        mem_addr  <= {sel_addr[31:2], 2'b00};
        mem_wdata <= dm_wdata;
        wait_cnt  <= '0;
        last_dm   <= pick_dm;
        if ((|sel_addr[1:0]) || (pick_dm && dm_rd && dm_wr)) err <= 1'b1;
      end else if (finish) begin
        mem_en <= 1'b0;
        mem_we <= 1'b0;
        if (state == IF_BUSY) begin
          if_gnt   <= 1'b1;
          if_rdata <= rd_data;
        end else begin
          dm_done <= 1'b1;
          if (!mem_we) dm_rdata <= rd_data;
        end
        if (tmo) err <= 1'b1;
      end else if (state == IF_BUSY || state == DM_BUSY) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TMO_CYC, default 16, meaning the number of cycles waited for mem_ready before an access aborts.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port if_req, input, 1 bit: instruction fetch request, held until if_gnt.
REQ-005 SHALL have port if_addr, input, 32 bits: fetch byte address.
REQ-006 SHALL have port if_gnt, output, 1 bit: one-cycle pulse meaning if_rdata is valid.
REQ-007 SHALL have port if_rdata, output, 32 bits: fetched instruction word.
REQ-008 SHALL have ports dm_rd and dm_wr, input, 1 bit each: data read and write requests, held until dm_done.
REQ-009 SHALL have ports dm_addr and dm_wdata, input, 32 bits each: data address and store data.
REQ-010 SHALL have port dm_done, output, 1 bit: one-cycle pulse meaning the data access has completed.
REQ-011 SHALL have port dm_rdata, output, 32 bits: load data.
REQ-012 SHALL have ports mem_en and mem_we, output, 1 bit each: memory access enable and write enable.
REQ-013 SHALL have ports mem_addr and mem_wdata, output, 32 bits each: memory address and write data.
REQ-014 SHALL have port mem_rdata, input, 32 bits: memory read data.
REQ-015 SHALL have port mem_ready, input, 1 bit: memory completion, sampled only while mem_en=1.
REQ-016 SHALL have port stall, output, 1 bit: pipeline hold, combinational.
REQ-017 SHALL have port err, output, 1 bit: sticky error flag.

Function
REQ-018 SHALL implement FSM states IDLE, IF_BUSY, DM_BUSY and RESP.
REQ-019 IDLE: dm request only -> DM_BUSY; if_req only -> IF_BUSY; both -> the side not granted last (last_gnt), then last_gnt updates; neither -> stay in IDLE.
REQ-020 On entry to a BUSY state SHALL register mem_en=1, mem_addr={addr[31:2],2'b00}, mem_wdata=dm_wdata, and mem_we=dm_wr (mem_we=0 for IF_BUSY); these hold constant while in BUSY.
REQ-021 BUSY with mem_ready=1 at an edge SHALL register mem_rdata into if_rdata or dm_rdata (dm_rdata unchanged for writes), pulse if_gnt or dm_done for exactly 1 cycle, drop mem_en and mem_we, and go to RESP.
REQ-022 RESP SHALL last exactly 1 cycle, ignore all requests, then go to IDLE; minimum issue spacing is 3 cycles, minimum latency is request-to-strobe 2 edges.
REQ-023 A wait counter SHALL clear on BUSY entry and increment each BUSY cycle without mem_ready; reaching TMO_CYC-1 SHALL abort: strobe asserted, read data forced to 32'h0, err set, state goes to RESP.
REQ-024 stall SHALL equal (if_req & ~if_gnt) | ((dm_rd|dm_wr) & ~dm_done).
REQ-025 dm_rd=dm_wr=1 in the same sampled cycle SHALL be executed as a write and SHALL set err.
REQ-026 A misaligned accepted address (addr[1:0]!=0) SHALL set err; the access proceeds on the aligned word.
REQ-027 err SHALL be sticky and cleared only by reset.
REQ-028 A request change or drop during BUSY SHALL be ignored; the latched access completes.

Reset
REQ-029 rst_n=0 SHALL asynchronously force state IDLE, last_gnt=IF (data wins the first tie), counter 0, err 0, and all outputs 0 except stall, which follows REQ-024.
REQ-030 Reset asserted during BUSY SHALL abort the access with no strobe; the first request after release is arbitrated afresh.

Verification
REQ-031 if_req, if_addr=0x40, mem_ready one cycle after mem_en, mem_rdata=0x8C020004 -> mem_addr=0x40, mem_we=0, if_gnt one pulse, if_rdata=0x8C020004, stall drops with the gnt.
REQ-032 if_req and dm_wr together out of reset, dm_addr=0x100, dm_wdata=0xDEADBEEF -> write first (mem_we=1), then the fetch; next tie goes to data.
REQ-033 dm_rd, mem_ready never asserted -> dm_done after 16 BUSY cycles, dm_rdata=0, err=1 and held until reset.
REQ-034 dm_rd=dm_wr=1 at dm_addr=0x102 -> mem_addr=0x100, mem_we=1, err=1.
REQ-035 rst_n low mid-DM_BUSY -> mem_en=0 immediately, no dm_done, state IDLE, err=0.
REQ-036 Back-to-back if_req held with mem_ready tied 1 -> if_gnt every 3rd cycle; if_addr changed during BUSY is not reflected in mem_addr.
